// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of pending stores with word-granular store-to-load lookup.
// Optional push trace is compiled in when STORE_BUF_TRACE_EN is defined.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        storeValid,
  input  logic [31:0] storeAddress,
  input  logic [31:0] storeData,
  input  logic [3:0]  storeByteEnable,
  input  logic [31:0] storePC,
  output logic        storeReady,
  input  logic        loadValid,
  input  logic [31:0] loadAddress,
  input  logic [3:0]  loadByteMask,
  output logic        loadHit,
  output logic [31:0] loadHitData,
  output logic        loadConflict,
  input  logic        memBusy,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memDebugPC,
  output logic        empty
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             push;
  logic             pop;

  // Byte offset bits never take part in the word-granular match.
  logic             unused_load_offset;
  assign unused_load_offset = ^loadAddress[1:0];

  assign storeReady     = (count_q != DEPTH_CNT);
  assign empty          = (count_q == '0);
  assign memWriteEnable = !empty && !memBusy;
  assign push           = storeValid && storeReady;
  assign pop            = memWriteEnable;

  assign memAddress    = empty ? 32'h0 : addr_q[head_q];
  assign memWriteData  = empty ? 32'h0 : data_q[head_q];
  assign memByteEnable = empty ? 4'h0  : be_q[head_q];
  assign memDebugPC    = empty ? 32'h0 : pc_q[head_q];

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; validity is derived from head/count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (tail_q == PTR_W'(gi))) begin
          addr_q[gi] <= storeAddress;
          data_q[gi] <= storeData;
          be_q[gi]   <= storeByteEnable;
          pc_q[gi]   <= storePC;
        end
      end
    end
  endgenerate

  // Walk oldest to youngest so the last match seen is the youngest one.
  logic             match_found;
  logic [31:0]      match_data;
  logic [3:0]       match_be;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    match_found = 1'b0;
    match_data  = 32'h0;
    match_be    = 4'h0;
    scan_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + k[PTR_W-1:0];
      if (((PTR_W + 1)'(k) < count_q) &&
          (addr_q[scan_idx][31:2] == loadAddress[31:2])) begin
        match_found = 1'b1;
        match_data  = data_q[scan_idx];
        match_be    = be_q[scan_idx];
      end
    end
  end

  assign loadHit      = loadValid && match_found && ((match_be & loadByteMask) == loadByteMask);
  assign loadConflict = loadValid && match_found && !loadHit;
  assign loadHitData  = loadHit ? match_data : 32'h0;

`ifdef STORE_BUF_TRACE_EN
  logic [31:0] trace_mask;
  assign trace_mask = {{8{storeByteEnable[3]}}, {8{storeByteEnable[2]}},
                       {8{storeByteEnable[1]}}, {8{storeByteEnable[0]}}};

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      $display("%d@%h: *%h <= %h", $time, storePC, storeAddress, storeData & trace_mask);
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain, full, wrap, forwarding, conflict, reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        storeValid = 1'b0;
  logic [31:0] storeAddress = 32'h0;
  logic [31:0] storeData = 32'h0;
  logic [3:0]  storeByteEnable = 4'h0;
  logic [31:0] storePC = 32'h0;
  logic        storeReady;
  logic        loadValid = 1'b0;
  logic [31:0] loadAddress = 32'h0;
  logic [3:0]  loadByteMask = 4'h0;
  logic        loadHit;
  logic [31:0] loadHitData;
  logic        loadConflict;
  logic        memBusy = 1'b0;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  memByteEnable;
  logic [31:0] memDebugPC;
  logic        empty;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .storeValid(storeValid), .storeAddress(storeAddress), .storeData(storeData),
    .storeByteEnable(storeByteEnable), .storePC(storePC), .storeReady(storeReady),
    .loadValid(loadValid), .loadAddress(loadAddress), .loadByteMask(loadByteMask),
    .loadHit(loadHit), .loadHitData(loadHitData), .loadConflict(loadConflict),
    .memBusy(memBusy), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
    .memWriteData(memWriteData), .memByteEnable(memByteEnable), .memDebugPC(memDebugPC),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Memory-side log: one line per committed write.
  always @(posedge clk) begin
    if (!reset && memWriteEnable) begin
      wr_addr_q.push_back(memAddress);
      wr_data_q.push_back(memWriteData);
      $display("mem write: addr=%h data=%h be=%b pc=%h", memAddress, memWriteData, memByteEnable, memDebugPC);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, required completion before it");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] pc);
    storeValid = 1'b1; storeAddress = a; storeData = d; storeByteEnable = be; storePC = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; memBusy = 1'b0;
    cyc(); cyc();
    reset = 1'b0; loadValid = 1'b1; loadAddress = 32'h0; loadByteMask = 4'hF;
    #1;
    total_cnt++; if (storeReady !== 1'b1) $display("FAIL reset_ready: got %b want 1", storeReady); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (memWriteEnable !== 1'b0) $display("FAIL reset_we: got %b want 0", memWriteEnable); else pass_cnt++;
    total_cnt++; if (loadHit !== 1'b0) $display("FAIL reset_hit: got %b want 0", loadHit); else pass_cnt++;
    total_cnt++; if (loadConflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", loadConflict); else pass_cnt++;
    loadValid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_drain();
    wr_addr_q.delete(); wr_data_q.delete();
    memBusy = 1'b0;
    set_store(32'h10, 32'hDEADBEEF, 4'hF, 32'h100);
    cyc();
    storeValid = 1'b0;
    #1;
    total_cnt++; if (memWriteEnable !== 1'b1) $display("FAIL single_we: got %b want 1", memWriteEnable); else pass_cnt++;
    total_cnt++; if (memAddress !== 32'h10) $display("FAIL single_addr: got %h want 00000010", memAddress); else pass_cnt++;
    total_cnt++; if (memWriteData !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", memWriteData); else pass_cnt++;
    total_cnt++; if (memByteEnable !== 4'hF) $display("FAIL single_be: got %b want 1111", memByteEnable); else pass_cnt++;
    total_cnt++; if (memDebugPC !== 32'h100) $display("FAIL single_pc: got %h want 00000100", memDebugPC); else pass_cnt++;
    cyc();
    total_cnt++; if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (memWriteEnable !== 1'b0) $display("FAIL single_we_after: got %b want 0", memWriteEnable); else pass_cnt++;
    total_cnt++; if (memAddress !== 32'h0) $display("FAIL single_addr_empty: got %h want 00000000", memAddress); else pass_cnt++;
    total_cnt++; if (wr_addr_q.size() != 1) $display("FAIL single_wr_count: got %0d want 1", wr_addr_q.size()); else pass_cnt++;
    $display("test_single_drain done");
  endtask

  task automatic test_full();
    wr_addr_q.delete(); wr_data_q.delete();
    memBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_store(32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 32'h200 + 32'(4 * i));
      cyc();
    end
    storeValid = 1'b0;
    #1;
    total_cnt++; if (storeReady !== 1'b0) $display("FAIL full_ready: got %b want 0", storeReady); else pass_cnt++;
    total_cnt++; if (memWriteEnable !== 1'b0) $display("FAIL full_busy_we: got %b want 0", memWriteEnable); else pass_cnt++;
    set_store(32'h99C, 32'h55555555, 4'hF, 32'h300);
    cyc();
    storeValid = 1'b0;
    #1;
    total_cnt++; if (storeReady !== 1'b0) $display("FAIL full_fifth_ready: got %b want 0", storeReady); else pass_cnt++;
    total_cnt++; if (memAddress !== 32'h40) $display("FAIL full_fifth_head: got %h want 00000040", memAddress); else pass_cnt++;
    memBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if (memWriteEnable !== 1'b1 || memAddress !== 32'h40 + 32'(4 * i))
        $display("FAIL full_drain_%0d: got we=%b addr=%h want we=1 addr=%h", i, memWriteEnable, memAddress, 32'h40 + 32'(4 * i));
      else pass_cnt++;
      cyc();
    end
    #1;
    total_cnt++; if (empty !== 1'b1) $display("FAIL full_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (wr_addr_q.size() != 4) $display("FAIL full_wr_count: got %0d want 4", wr_addr_q.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      total_cnt++;
      if (wr_data_q[i] !== 32'hA0 + 32'(i)) $display("FAIL full_order_%0d: got %h want %h", i, wr_data_q[i], 32'hA0 + 32'(i));
      else pass_cnt++;
    end
    $display("test_full done");
  endtask

  task automatic test_wrap();
    wr_addr_q.delete(); wr_data_q.delete();
    memBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, 32'h400);
      cyc();
    end
    memBusy = 1'b0;
    for (int j = 3; j < 11; j++) begin
      set_store(32'h100 + 32'(4 * j), 32'hB0 + 32'(j), 4'hF, 32'h400);
      #1;
      total_cnt++;
      if (storeReady !== 1'b1 || memWriteEnable !== 1'b1 || memAddress !== 32'h100 + 32'(4 * (j - 3)))
        $display("FAIL wrap_step_%0d: got ready=%b we=%b addr=%h want ready=1 we=1 addr=%h",
                 j, storeReady, memWriteEnable, memAddress, 32'h100 + 32'(4 * (j - 3)));
      else pass_cnt++;
      cyc();
    end
    storeValid = 1'b0;
    cyc(); cyc();
    #1;
    total_cnt++; if (empty !== 1'b0) $display("FAIL wrap_count3: got empty=%b want 0 after two drains", empty); else pass_cnt++;
    cyc();
    total_cnt++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (wr_addr_q.size() != 11) $display("FAIL wrap_wr_count: got %0d want 11", wr_addr_q.size()); else pass_cnt++;
    for (int k = 0; k < 11 && k < wr_addr_q.size(); k++) begin
      total_cnt++;
      if (wr_addr_q[k] !== 32'h100 + 32'(4 * k) || wr_data_q[k] !== 32'hB0 + 32'(k))
        $display("FAIL wrap_order_%0d: got %h/%h want %h/%h", k, wr_addr_q[k], wr_data_q[k], 32'h100 + 32'(4 * k), 32'hB0 + 32'(k));
      else pass_cnt++;
    end
    $display("test_wrap done");
  endtask

  task automatic test_forward();
    memBusy = 1'b1;
    set_store(32'h20, 32'h11111111, 4'hF, 32'h500); cyc();
    set_store(32'h20, 32'h22222222, 4'hF, 32'h504); cyc();
    storeValid = 1'b0;
    loadValid = 1'b1; loadAddress = 32'h22; loadByteMask = 4'b1100;
    #1;
    total_cnt++; if (loadHit !== 1'b1) $display("FAIL fwd_hit: got %b want 1", loadHit); else pass_cnt++;
    total_cnt++; if (loadHitData !== 32'h22222222) $display("FAIL fwd_data: got %h want 22222222", loadHitData); else pass_cnt++;
    total_cnt++; if (loadConflict !== 1'b0) $display("FAIL fwd_conflict: got %b want 0", loadConflict); else pass_cnt++;
    loadAddress = 32'h24; loadByteMask = 4'hF;
    #1;
    total_cnt++; if (loadHit !== 1'b0 || loadConflict !== 1'b0 || loadHitData !== 32'h0)
      $display("FAIL fwd_miss: got hit=%b conf=%b data=%h want 0/0/0", loadHit, loadConflict, loadHitData); else pass_cnt++;
    loadValid = 1'b0; loadAddress = 32'h20;
    #1;
    total_cnt++; if (loadHit !== 1'b0) $display("FAIL fwd_novalid: got %b want 0", loadHit); else pass_cnt++;
    memBusy = 1'b0;
    cyc(); cyc();
    total_cnt++; if (empty !== 1'b1) $display("FAIL fwd_drain: got %b want 1", empty); else pass_cnt++;
    $display("test_forward done");
  endtask

  task automatic test_conflict();
    memBusy = 1'b1;
    set_store(32'h30, 32'h0000ABCD, 4'b0011, 32'h600); cyc();
    storeValid = 1'b0;
    loadValid = 1'b1; loadAddress = 32'h30; loadByteMask = 4'hF;
    #1;
    total_cnt++; if (loadConflict !== 1'b1) $display("FAIL conf_set: got %b want 1", loadConflict); else pass_cnt++;
    total_cnt++; if (loadHit !== 1'b0 || loadHitData !== 32'h0) $display("FAIL conf_nohit: got hit=%b data=%h want 0/0", loadHit, loadHitData); else pass_cnt++;
    loadByteMask = 4'b0011;
    #1;
    total_cnt++; if (loadHit !== 1'b1 || loadHitData !== 32'h0000ABCD) $display("FAIL conf_subset_hit: got hit=%b data=%h want 1/0000abcd", loadHit, loadHitData); else pass_cnt++;
    loadByteMask = 4'hF; memBusy = 1'b0;
    #1;
    total_cnt++; if (loadConflict !== 1'b1 || memWriteEnable !== 1'b1)
      $display("FAIL conf_popping: got conf=%b we=%b want 1/1", loadConflict, memWriteEnable); else pass_cnt++;
    cyc();
    total_cnt++; if (loadConflict !== 1'b0) $display("FAIL conf_clear: got %b want 0", loadConflict); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL conf_empty: got %b want 1", empty); else pass_cnt++;
    loadValid = 1'b0;
    $display("test_conflict done");
  endtask

  task automatic test_reset_mid();
    memBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(32'h700 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, 32'h700);
      cyc();
    end
    storeValid = 1'b0;
    #1;
    total_cnt++; if (empty !== 1'b0) $display("FAIL rmid_pending: got empty=%b want 0", empty); else pass_cnt++;
    wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total_cnt++; if (empty !== 1'b1) $display("FAIL rmid_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (storeReady !== 1'b1) $display("FAIL rmid_ready: got %b want 1", storeReady); else pass_cnt++;
    memBusy = 1'b0;
    #1;
    total_cnt++; if (memWriteEnable !== 1'b0) $display("FAIL rmid_we: got %b want 0", memWriteEnable); else pass_cnt++;
    cyc(); cyc();
    total_cnt++; if (wr_addr_q.size() != 0) $display("FAIL rmid_writes: got %0d want 0", wr_addr_q.size()); else pass_cnt++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_full();
    test_wrap();
    test_forward();
    test_conflict();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the MEM-stage store path and the data memory write port.
- Accepts one store per cycle from the pipeline and retires the oldest one to data memory whenever the port is not claimed by a load.
- Provides word-granular store-to-load lookup so that loads see buffered stores.
- Signals a conflict (pipeline stall) when a buffered store only partially overlaps a load.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- storeValid  in  1  MEM stage presents a store this cycle.
- storeAddress  in  32  byte address of the store.
- storeData  in  32  store data, already lane-aligned.
- storeByteEnable  in  4  byte lanes written; bit n selects byte n.
- storePC  in  32  PC of the store instruction, used for the debug trace.
- storeReady  out  1  buffer can accept a store.
- loadValid  in  1  MEM stage performs a load this cycle.
- loadAddress  in  32  byte address of the load.
- loadByteMask  in  4  byte lanes the load needs.
- loadHit  out  1  youngest matching entry fully covers loadByteMask.
- loadHitData  out  32  data word of that entry.
- loadConflict  out  1  matching entry exists but hit conditions fail; stall the load.
- memBusy  in  1  data memory port is used by a load this cycle.
- memWriteEnable  out  1  write head entry to memory this cycle.
- memAddress  out  32  head entry address.
- memWriteData  out  32  head entry data.
- memByteEnable  out  4  head entry byte enables.
- memDebugPC  out  32  head entry PC.
- empty  out  1  no entries buffered; used for sync/syscall drain.

Behaviour:
- **Storage:** circular FIFO with head pointer, tail pointer and a count register of width PTR_W+1. Each entry holds address, data, byte enable and PC.
- **Reset:** on clk edge with reset=1, count, head and tail clear to 0; entry contents are don't-care. After reset: storeReady=1, empty=1, memWriteEnable=0, loadHit=0, loadConflict=0.
- **Output decodes:** storeReady = (count != DEPTH); there is no same-cycle full bypass. empty = (count == 0).
- **Push:** storeValid && storeReady writes the entry at tail; tail and count update on the same edge. storeValid while not ready is ignored; the pipeline must hold the store and stall. A store with byte enable 0000 is still pushed.
- **Drain:** memWriteEnable = !empty && !memBusy, combinational. mem* outputs show the head entry whenever not empty and are 0 when empty. Pop occurs on the edge where memWriteEnable=1; the memory commits on that same edge.
- **Simultaneous push and pop:** count unchanged, both pointers advance. When full, a pop does not enable a push in the same cycle.
- **Wrap-around:** pointers wrap modulo DEPTH.
- **Order:** strict FIFO; no write merging.
- **Load lookup:** combinational against registered entries only. A store being pushed in the same cycle is not visible, so the pipeline must not issue a load in the same cycle as an older store. The head entry being popped in the same cycle remains visible.
  - Match: entry valid and entry address[31:2] == loadAddress[31:2].
  - Youngest match Y is the match closest to tail.
  - loadHit = loadValid && Y exists && (Y.byteEnable & loadByteMask) == loadByteMask; loadHitData = Y.data.
  - loadConflict = loadValid && any match && !loadHit.
  - Both outputs are 0 when loadValid=0; loadHitData is 0 when loadHit=0.
  - A conflict clears as the buffer drains, because memBusy is low during the stall.
- **Latency:** a store becomes visible to lookup 1 cycle after push and reaches memory at least 1 cycle after push.
- **Reset mid-operation:** buffered stores are discarded and not written.

Optional Feature:
- Macro: STORE_BUF_TRACE_EN.
- When defined, each push prints via $display "%d@%h: *%h <= %h" using $time, storePC, storeAddress and storeData masked to the enabled lanes.
- When undefined, no display code is compiled; functional behaviour is identical.

Test Plan:
- Reset, then push store addr 0x10 data 0xDEADBEEF be 1111 with memBusy=0 -> next cycle memWriteEnable=1, memAddress=0x10, memWriteData=0xDEADBEEF; following cycle empty=1.
- memBusy=1, push 4 stores -> storeReady=0 after the fourth push. Fifth storeValid -> no state change. Release memBusy -> 4 writes in push order over 4 consecutive cycles.
- Fill 3 entries, then push and pop in the same cycle over 8 cycles -> count stays 3, pointers wrap, memory write order matches push order.
- memBusy=1: push 0x20 data 0x11111111 be 1111, then 0x20 data 0x22222222 be 1111. Load 0x22 mask 1100 -> loadHit=1, loadHitData=0x22222222.
- Buffer holds 0x30 be 0011; load 0x30 mask 1111 -> loadConflict=1, loadHit=0. Drop memBusy -> after the entry drains, loadConflict=0.
- Assert reset with 3 entries pending -> no further memWriteEnable, empty=1, storeReady=1 on the next cycle.
